// File: rtl/enigma_rotor_stack.sv
// ============================================================================
//  Module   : enigma_rotor_stack
//  Function : three-rotor Enigma stage (I-II-III) with stepping, double step,
//             external reflector round trip and valid/ready output handshake.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module enigma_rotor_stack #(
  parameter logic [4:0] NOTCH_L = 5'd16,
  parameter logic [4:0] NOTCH_M = 5'd4,
  parameter logic [4:0] NOTCH_R = 5'd21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] pos_l_in,
  input  logic [4:0] pos_m_in,
  input  logic [4:0] pos_r_in,
  input  logic [4:0] ring_l,
  input  logic [4:0] ring_m,
  input  logic [4:0] ring_r,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] in_code,
  output logic [4:0] refl_code,
  input  logic [4:0] refl_val,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_code,
  output logic [4:0] pos_l,
  output logic [4:0] pos_m,
  output logic [4:0] pos_r
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_STEP  = 4'd1;
  localparam logic [3:0] S_FWD_R = 4'd2;
  localparam logic [3:0] S_FWD_M = 4'd3;
  localparam logic [3:0] S_FWD_L = 4'd4;
  localparam logic [3:0] S_REFL  = 4'd5;
  localparam logic [3:0] S_REV_L = 4'd6;
  localparam logic [3:0] S_REV_M = 4'd7;
  localparam logic [3:0] S_REV_R = 4'd8;
  localparam logic [3:0] S_DONE  = 4'd9;

  // A notch outside 0..25 could never match; such a set disables turnover outright.
  localparam bit c_notch_ok = (NOTCH_L < 5'd26) && (NOTCH_M < 5'd26) && (NOTCH_R < 5'd26);

  // Rows: III fwd, II fwd, I fwd, I inv, II inv, III inv (pass order).
  localparam logic [4:0] c_wire [6][26] = '{
    '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14},
    '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd24, 5'd15, 5'd21, 5'd14, 5'd5, 5'd4},
    '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9},
    '{5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
      5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9},
    '{5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd24, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
      5'd19, 5'd23, 5'd21, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd22, 5'd12, 5'd8, 5'd20, 5'd18},
    '{5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
      5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12}
  };

  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] t;
    t = {1'b0, a} + {1'b0, b};
    return (t >= 6'd26) ? 5'(t - 6'd26) : t[4:0];
  endfunction

  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] t;
    t = {1'b0, a} - {1'b0, b};
    return (a < b) ? 5'(t + 6'd26) : t[4:0];
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] a);
    return (a == 5'd25) ? 5'd0 : a + 5'd1;
  endfunction

  logic [3:0] state_q, state_d;
  logic [4:0] pos_l_q, pos_l_d, pos_m_q, pos_m_d, pos_r_q, pos_r_d;
  logic [4:0] data_q, data_d, out_code_q, out_code_d;
  logic       bad_q, bad_d, out_valid_q, out_valid_d;
  logic [2:0] w_sel;
  logic [4:0] w_pos, w_ring, w_shift, w_rot;
  logic       w_turn_m;

  always_comb begin
    w_sel  = 3'd0;
    w_pos  = pos_r_q;
    w_ring = ring_r;
    case (state_q)
      S_FWD_M: begin w_sel = 3'd1; w_pos = pos_m_q; w_ring = ring_m; end
      S_FWD_L: begin w_sel = 3'd2; w_pos = pos_l_q; w_ring = ring_l; end
      S_REV_L: begin w_sel = 3'd3; w_pos = pos_l_q; w_ring = ring_l; end
      S_REV_M: begin w_sel = 3'd4; w_pos = pos_m_q; w_ring = ring_m; end
      S_REV_R: begin w_sel = 3'd5; end
      default: ;
    endcase
    w_shift = sub26(w_pos, w_ring);
    w_rot   = sub26(c_wire[w_sel][add26(data_q, w_shift)], w_shift);
  end

  assign w_turn_m = c_notch_ok && (pos_m_q == NOTCH_M);

  always_comb begin
    state_d     = state_q;
    pos_l_d     = pos_l_q;
    pos_m_d     = pos_m_q;
    pos_r_d     = pos_r_q;
    data_d      = data_q;
    bad_d       = bad_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          pos_l_d = pos_l_in;
          pos_m_d = pos_m_in;
          pos_r_d = pos_r_in;
        end else if (in_valid) begin
          data_d  = in_code;
          bad_d   = (in_code > 5'd25);
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (!bad_q) begin
          pos_r_d = inc26(pos_r_q);
          if (w_turn_m || (c_notch_ok && pos_r_q == NOTCH_R)) pos_m_d = inc26(pos_m_q);
          if (w_turn_m) pos_l_d = inc26(pos_l_q);
        end
        state_d = S_FWD_R;
      end
      S_FWD_R, S_FWD_M, S_FWD_L, S_REV_L, S_REV_M, S_REV_R: begin
        if (!bad_q) data_d = w_rot;
        state_d = state_q + 4'd1;
      end
      S_REFL: begin
        if (!bad_q) data_d = refl_val;
        state_d = S_REV_L;
      end
      S_DONE: begin
        // First DONE cycle publishes the result; later cycles wait for the consumer.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_code_d  = data_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_l_q     <= 5'd0;
      pos_m_q     <= 5'd0;
      pos_r_q     <= 5'd0;
      data_q      <= 5'd0;
      bad_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_code_q  <= 5'd0;
    end else begin
      state_q     <= state_d;
      pos_l_q     <= pos_l_d;
      pos_m_q     <= pos_m_d;
      pos_r_q     <= pos_r_d;
      data_q      <= data_d;
      bad_q       <= bad_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & ~load;
  assign refl_code = (state_q == S_REFL && !bad_q) ? data_q : 5'd0;
  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign pos_l     = pos_l_q;
  assign pos_m     = pos_m_q;
  assign pos_r     = pos_r_q;

endmodule

`default_nettype wire

// File: tb/tb_enigma_rotor_stack.sv
// ============================================================================
//  Module   : tb_enigma_rotor_stack
//  Function : bench for enigma_rotor_stack with reflector B and a letter model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_enigma_rotor_stack;

  typedef struct {
    bit ld;
    int pl, pm, pr;
    int rl, rm, rr;
    int key;
    int eo, el, em, er;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, load, in_valid, out_ready;
  logic [4:0] pos_l_in, pos_m_in, pos_r_in, ring_l, ring_m, ring_r, in_code, refl_val;
  logic       in_ready, out_valid;
  logic [4:0] refl_code, out_code, pos_l, pos_m, pos_r;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   ml, mm, mr;
  logic [4:0] exp_q[$];
  vec_t tv[$];

  string W1 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  string W2 = "AJDKSIRUXBLHWTMCQGZNYPVOFE";
  string W3 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enigma_rotor_stack dut (
    .clk(clk), .rst(rst), .load(load),
    .pos_l_in(pos_l_in), .pos_m_in(pos_m_in), .pos_r_in(pos_r_in),
    .ring_l(ring_l), .ring_m(ring_m), .ring_r(ring_r),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .refl_code(refl_code), .refl_val(refl_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r)
  );

  function automatic int reflb(input int c);
    string t;
    t = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
    if (c < 0 || c > 25) return 0;
    return int'(t[c]) - 65;
  endfunction

  always_comb refl_val = 5'(reflb(int'(refl_code)));

  function automatic int rotor(input string w, input int c, input int p, input int g, input bit inv);
    int s, x, y;
    s = (p - g + 26) % 26;
    x = (c + s) % 26;
    y = 0;
    if (!inv) y = int'(w[x]) - 65;
    else for (int j = 0; j < 26; j++) if (int'(w[j]) - 65 == x) y = j;
    return (y - s + 26) % 26;
  endfunction

  function automatic int model_key(input int k, input int rl, input int rm, input int rr);
    bit mid, rnotch;
    int c;
    if (k > 25) return k;
    mid    = (mm == 4);
    rnotch = (mr == 21);
    if (mid || rnotch) mm = (mm + 1) % 26;
    if (mid) ml = (ml + 1) % 26;
    mr = (mr + 1) % 26;
    c = rotor(W3, k, mr, rr, 1'b0);
    c = rotor(W2, c, mm, rm, 1'b0);
    c = rotor(W1, c, ml, rl, 1'b0);
    c = reflb(c);
    c = rotor(W1, c, ml, rl, 1'b1);
    c = rotor(W2, c, mm, rm, 1'b1);
    return rotor(W3, c, mr, rr, 1'b1);
  endfunction

  function automatic void add(input bit ld, input int pl, input int pm, input int pr,
                              input int rl, input int rm, input int rr, input int key);
    vec_t v;
    v.ld = ld; v.pl = pl; v.pm = pm; v.pr = pr;
    v.rl = rl; v.rm = rm; v.rr = rr; v.key = key;
    if (ld) begin ml = pl; mm = pm; mr = pr; end
    v.eo = model_key(key, rl, rm, rr);
    v.el = ml; v.em = mm; v.er = mr;
    tv.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else chk("out_code", int'(out_code), int'(exp_q.pop_front()));
    end
  end

  task automatic do_load(input int pl, input int pm, input int pr);
    pos_l_in = 5'(pl); pos_m_in = 5'(pm); pos_r_in = 5'(pr);
    load = 1'b1;
    @(posedge clk); #1 load = 1'b0;
    @(negedge clk);
    chk("load_pos_l", int'(pos_l), pl);
    chk("load_pos_m", int'(pos_m), pm);
    chk("load_pos_r", int'(pos_r), pr);
  endtask

  task automatic send_key(input int key, input int eo, input int el, input int em, input int er);
    int n, t0;
    in_code = 5'(key);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(5'(eo));
    @(posedge clk); #1 t0 = cyc; in_valid = 1'b0;
    @(negedge clk);
    chk("busy_in_ready", int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("latency", cyc - t0, 9);
    chk("step_pos_l", int'(pos_l), el);
    chk("step_pos_m", int'(pos_m), em);
    chk("step_pos_r", int'(pos_r), er);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, n, oc;
    bit ok;
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_code = 5'd0;
    pos_l_in = 5'd0; pos_m_in = 5'd0; pos_r_in = 5'd0;
    ring_l = 5'd0; ring_m = 5'd0; ring_r = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_code", int'(out_code), 0);
    chk("rst_refl_code", int'(refl_code), 0);
    chk("rst_pos_l", int'(pos_l), 0);
    chk("rst_pos_m", int'(pos_m), 0);
    chk("rst_pos_r", int'(pos_r), 0);

    // Vector table: rings 0 then 1, double step from ADU, wraps, out-of-range codes, random.
    add(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 1, 0);
    add(1, 0, 3, 20, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 25, 0, 0, 0, 7);
    add(1, 25, 25, 25, 0, 0, 0, 12);
    add(0, 0, 0, 0, 0, 0, 0, 27);
    add(0, 0, 0, 0, 0, 0, 0, 31);
    for (int i = 0; i < 8; i++)
      add(i[0] == 1'b0, $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25),
          $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));

    foreach (tv[i]) begin
      ring_l = 5'(tv[i].rl); ring_m = 5'(tv[i].rm); ring_r = 5'(tv[i].rr);
      if (tv[i].ld) do_load(tv[i].pl, tv[i].pm, tv[i].pr);
      send_key(tv[i].key, tv[i].eo, tv[i].el, tv[i].em, tv[i].er);
    end

    // Consumer stall in DONE; load pulsed mid-stall must be ignored.
    ring_l = 5'd2; ring_m = 5'd3; ring_r = 5'd4;
    e = model_key(11, 2, 3, 4);
    out_ready = 1'b0; in_code = 5'd11; in_valid = 1'b1;
    exp_q.push_back(5'(e));
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin @(negedge clk); n++; end
    chk("stall_valid", int'(out_valid), 1);
    oc = int'(out_code);
    ok = 1'b1;
    pos_l_in = 5'd1; pos_m_in = 5'd1; pos_r_in = 5'd1;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) load = 1'b1;
      @(negedge clk);
      if (!out_valid || int'(out_code) != oc) ok = 1'b0;
      if (k < 10 && in_ready) ok = 1'b0;
      if (int'(pos_l) != ml || int'(pos_m) != mm || int'(pos_r) != mr) ok = 1'b0;
    end
    chk("stall_hold", int'(ok), 1);
    @(posedge clk); #1 load = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);

    // Reset while in FWD_M aborts the character.
    in_code = 5'd6; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    ml = 0; mm = 0; mr = 0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_pos_l", int'(pos_l), 0);
    chk("abort_pos_m", int'(pos_m), 0);
    chk("abort_pos_r", int'(pos_r), 0);
    ok = 1'b1;
    repeat (15) begin @(negedge clk); if (out_valid) ok = 1'b0; end
    chk("abort_no_valid", int'(ok), 1);

    // Simultaneous load and in_valid: load wins, key is not taken.
    @(posedge clk); #1;
    pos_l_in = 5'd7; pos_m_in = 5'd8; pos_r_in = 5'd9;
    in_code = 5'd2; load = 1'b1; in_valid = 1'b1;
    #1 chk("load_wins_in_ready", int'(in_ready), 0);
    @(posedge clk); #1 load = 1'b0; in_valid = 1'b0;
    ok = 1'b1;
    repeat (12) begin @(negedge clk); if (out_valid) ok = 1'b0; end
    chk("load_wins_no_key", int'(ok), 1);
    chk("load_wins_pos_l", int'(pos_l), 7);
    chk("load_wins_pos_m", int'(pos_m), 8);
    chk("load_wins_pos_r", int'(pos_r), 9);
    chk("load_wins_idle", int'(in_ready), 1);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
